// File: rtl/xmr_pipe_pkg.sv
// Shared helpers for the XMR pipeline-register bank: counter sizing and
// elaboration-time parameter sanity checks.
package xmr_pipe_pkg;

  // Width needed to count 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int num_ch, input int width, input int depth);
    return (num_ch >= 1) && (width >= 1) && (depth >= 1);
  endfunction

endpackage

// File: rtl/xmr_pipe_bank_if.sv
// Bus bundle between XMR sources/consumer and the pipeline bank.
// Channel c occupies [c*WIDTH +: WIDTH] of the data vectors and [c*CW +: CW] of inflight.
interface xmr_pipe_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int CW     = 2
);
  logic                     stall_i;
  logic                     flush_i;
  logic [NUM_CH-1:0]        in_valid_i;
  logic [NUM_CH*WIDTH-1:0]  in_data_i;
  logic [NUM_CH-1:0]        out_valid_o;
  logic [NUM_CH*WIDTH-1:0]  out_data_o;
  logic [NUM_CH*CW-1:0]     inflight_o;

  modport master (
    output stall_i, flush_i, in_valid_i, in_data_i,
    input  out_valid_o, out_data_o, inflight_o
  );

  modport slave (
    input  stall_i, flush_i, in_valid_i, in_data_i,
    output out_valid_o, out_data_o, inflight_o
  );
endinterface

// File: rtl/xmr_pipe_lane.sv
// One XMR channel: DEPTH valid/data register stages plus an occupancy counter.
// Every output comes straight from a flop.
module xmr_pipe_lane import xmr_pipe_pkg::*; #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter bit               GATE_DATA = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    inflight
);

  logic [DEPTH:1]             vld_q;
  logic [DEPTH:1][WIDTH-1:0]  dat_q;
  logic [CW-1:0]              cnt;

  // Index 0 is the live input so stage k always loads from index k-1.
  logic [DEPTH:0]             vld_pipe;
  logic [DEPTH:0][WIDTH-1:0]  dat_pipe;

  assign vld_pipe = {vld_q, in_valid};
  assign dat_pipe = {dat_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt   <= '0;
      for (int k = 1; k <= DEPTH; k++) dat_q[k] <= RESET_VAL;
    end else if (flush) begin
      vld_q <= '0;
      cnt   <= '0;
      for (int k = 1; k <= DEPTH; k++) dat_q[k] <= RESET_VAL;
    end else if (!stall) begin
      for (int k = 1; k <= DEPTH; k++) begin
        vld_q[k] <= vld_pipe[k-1];
        // Gated mode keeps the last real sample parked in an empty stage.
        if (!GATE_DATA || vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
      end
      cnt <= cnt + CW'(in_valid) - CW'(vld_q[DEPTH]);
    end
  end

  assign out_valid = vld_q[DEPTH];
  assign out_data  = dat_q[DEPTH];
  assign inflight  = cnt;

  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt) <= DEPTH);

  a_cnt_pop: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt) == $countones(vld_q));

  a_cnt_nowrap: assert property (@(posedge clk) disable iff (!rst_n)
    (!stall && !flush) |->
      !((cnt == '0) && vld_q[DEPTH] && !in_valid) &&
      !((int'(cnt) == DEPTH) && in_valid && !vld_q[DEPTH]));

endmodule

// File: rtl/xmr_pipe_bank.sv
// NUM_CH independent XMR pipeline lanes sharing stall and flush,
// with flat packing of the per-channel data and counters.
module xmr_pipe_bank import xmr_pipe_pkg::*; #(
  parameter int               NUM_CH    = 4,
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter bit               GATE_DATA = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  xmr_pipe_bank_if.slave  bus
);

  localparam int CW = cnt_w(DEPTH);

  if (!params_ok(NUM_CH, WIDTH, DEPTH)) begin : g_bad_params
    $error("xmr_pipe_bank: NUM_CH, WIDTH and DEPTH must all be >= 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    xmr_pipe_lane #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .GATE_DATA (GATE_DATA),
      .RESET_VAL (RESET_VAL),
      .CW        (CW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (bus.stall_i),
      .flush     (bus.flush_i),
      .in_valid  (bus.in_valid_i[c]),
      .in_data   (bus.in_data_i[c*WIDTH +: WIDTH]),
      .out_valid (bus.out_valid_o[c]),
      .out_data  (bus.out_data_o[c*WIDTH +: WIDTH]),
      .inflight  (bus.inflight_o[c*CW +: CW])
    );
  end

endmodule

// File: tb/tb_xmr_pipe_bank.sv
// Directed bench: A = gated DEPTH 2, B = ungated DEPTH 2, C = gated DEPTH 3,
// all driven by the same stimulus.
module tb_xmr_pipe_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [3:0]  iv;
  logic [31:0] id;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xmr_pipe_bank_if #(.NUM_CH(4), .WIDTH(8), .CW(2)) if_a ();
  xmr_pipe_bank_if #(.NUM_CH(4), .WIDTH(8), .CW(2)) if_b ();
  xmr_pipe_bank_if #(.NUM_CH(4), .WIDTH(8), .CW(2)) if_c ();

  assign if_a.stall_i = stall;  assign if_a.flush_i = flush;
  assign if_a.in_valid_i = iv;  assign if_a.in_data_i = id;
  assign if_b.stall_i = stall;  assign if_b.flush_i = flush;
  assign if_b.in_valid_i = iv;  assign if_b.in_data_i = id;
  assign if_c.stall_i = stall;  assign if_c.flush_i = flush;
  assign if_c.in_valid_i = iv;  assign if_c.in_data_i = id;

  xmr_pipe_bank #(.NUM_CH(4), .WIDTH(8), .DEPTH(2), .GATE_DATA(1'b1), .RESET_VAL(8'h00))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  xmr_pipe_bank #(.NUM_CH(4), .WIDTH(8), .DEPTH(2), .GATE_DATA(1'b0), .RESET_VAL(8'h00))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  xmr_pipe_bank #(.NUM_CH(4), .WIDTH(8), .DEPTH(3), .GATE_DATA(1'b1), .RESET_VAL(8'h00))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  typedef struct {
    logic        st;
    logic        fl;
    logic [3:0]  iv;
    logic [31:0] id;
    logic [3:0]  ov;     // dut_a expectations after the edge
    logic [31:0] od;
    logic [7:0]  inf;
    logic        chk_b;
    logic [31:0] od_b;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [3:0] v, input logic [31:0] d);
    stall = s; flush = f; iv = v; id = d;
  endtask

  // Inputs change on the falling edge; the rising edge captures them and
  // results are sampled at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // single beat + stall sequence on ch0/ch1
    tbl[0]  = '{1'b0, 1'b0, 4'b0001, 32'h000000A5, 4'b0000, 32'h00000000, 8'h01, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0001, 32'h000000A5, 8'h01, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 32'h000000A5, 8'h00, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0010, 32'h00000100, 4'b0000, 32'h000000A5, 8'h04, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0010, 32'h00000200, 4'b0010, 32'h000001A5, 8'h08, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'b0010, 32'h00000300, 4'b0010, 32'h000001A5, 8'h08, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'b0010, 32'h00000300, 4'b0010, 32'h000001A5, 8'h08, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'b0010, 32'h00000300, 4'b0010, 32'h000001A5, 8'h08, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 4'b0010, 32'h00000400, 4'b0010, 32'h000002A5, 8'h08, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0010, 32'h000004A5, 8'h04, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 32'h000004A5, 8'h00, 1'b0, 32'h0};
    // fill every channel, then flush together with stall
    tbl[11] = '{1'b0, 1'b0, 4'b1111, 32'h11223344, 4'b0000, 32'h000004A5, 8'h55, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 4'b1111, 32'h11223344, 4'b1111, 32'h11223344, 8'hAA, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 4'b1111, 32'h55667788, 4'b0000, 32'h00000000, 8'h00, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 32'h00000000, 8'h00, 1'b0, 32'h0};
    // data gating on ch2; B is the ungated build
    tbl[15] = '{1'b0, 1'b0, 4'b0100, 32'h003C0000, 4'b0000, 32'h00000000, 8'h10, 1'b1, 32'h00000000};
    tbl[16] = '{1'b0, 1'b0, 4'b0000, 32'h00FF0000, 4'b0100, 32'h003C0000, 8'h10, 1'b1, 32'h003C0000};
    tbl[17] = '{1'b0, 1'b0, 4'b0000, 32'h00FF0000, 4'b0000, 32'h003C0000, 8'h00, 1'b1, 32'h00FF0000};
    tbl[18] = '{1'b0, 1'b0, 4'b0000, 32'h00FF0000, 4'b0000, 32'h003C0000, 8'h00, 1'b1, 32'h00FF0000};
    tbl[19] = '{1'b0, 1'b0, 4'b0000, 32'h00FF0000, 4'b0000, 32'h003C0000, 8'h00, 1'b1, 32'h00FF0000};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset a.out_valid", 64'(if_a.out_valid_o), 64'h0);
    chk("reset a.out_data",  64'(if_a.out_data_o),  64'h0);
    chk("reset a.inflight",  64'(if_a.inflight_o),  64'h0);
    chk("reset c.inflight",  64'(if_c.inflight_o),  64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].id);
      cyc();
      chk($sformatf("row%0d a.out_valid", i), 64'(if_a.out_valid_o), 64'(tbl[i].ov));
      chk($sformatf("row%0d a.out_data", i),  64'(if_a.out_data_o),  64'(tbl[i].od));
      chk($sformatf("row%0d a.inflight", i),  64'(if_a.inflight_o),  64'(tbl[i].inf));
      if (tbl[i].chk_b)
        chk($sformatf("row%0d b.out_data", i), 64'(if_b.out_data_o), 64'(tbl[i].od_b));
    end

    // DEPTH=3 counter ramp, saturation with simultaneous enter/leave, drain
    begin
      logic [7:0] exp_inf [8];
      logic [3:0] exp_ov  [8];
      exp_inf = '{8'h40, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'h80, 8'h40, 8'h00};
      exp_ov  = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
      for (int i = 0; i < 8; i++) begin
        if (i < 5) drive(1'b0, 1'b0, 4'b1000, 32'h77000000);
        else       drive(1'b0, 1'b0, 4'b0000, 32'h00000000);
        cyc();
        chk($sformatf("depth3 step%0d c.inflight", i), 64'(if_c.inflight_o), 64'(exp_inf[i]));
        chk($sformatf("depth3 step%0d c.out_valid", i), 64'(if_c.out_valid_o), 64'(exp_ov[i]));
      end
    end

    // async reset with A full, asserted between clock edges
    drive(1'b0, 1'b0, 4'b1111, 32'hDEADBEEF);
    cyc();
    cyc();
    chk("full a.out_valid", 64'(if_a.out_valid_o), 64'hF);
    chk("full a.out_data",  64'(if_a.out_data_o),  64'hDEADBEEF);
    chk("full a.inflight",  64'(if_a.inflight_o),  64'hAA);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst a.out_valid", 64'(if_a.out_valid_o), 64'h0);
    chk("async rst a.out_data",  64'(if_a.out_data_o),  64'h0);
    chk("async rst a.inflight",  64'(if_a.inflight_o),  64'h0);
    chk("async rst b.out_data",  64'(if_b.out_data_o),  64'h0);
    chk("async rst c.inflight",  64'(if_c.inflight_o),  64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b0000, 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("post rst a.out_valid", 64'(if_a.out_valid_o), 64'h0);
    chk("post rst a.inflight",  64'(if_a.inflight_o),  64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
